// File: rtl/eespfal_lane_sequencer.sv
// EESPFAL lane sequencer: accepts x/k over valid/ready, drives the dual-rail operands,
// the 4-phase adiabatic clock and discharge enables of one lane, then samples s/s_bar
// into a held response. One transaction in flight at a time.
// Optional feature: define EESPFAL_RAIL_CHECK_EN to flag any result bit with s == s_bar.
module eespfal_lane_sequencer #(
  parameter int unsigned bits         = 4,
  parameter int unsigned BIT_SIZE     = 64,
  parameter int unsigned PHASE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] in_x,
  input  logic [BIT_SIZE-1:0] in_k,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] out_s,
  output logic                out_err,
  output logic [bits-1:0]     lane_clk,
  output logic [bits-1:0]     lane_dis,
  output logic                lane_dis_phase,
  output logic [BIT_SIZE-1:0] lane_x,
  output logic [BIT_SIZE-1:0] lane_x_bar,
  output logic [BIT_SIZE-1:0] lane_k,
  output logic [BIT_SIZE-1:0] lane_k_bar,
  input  logic [BIT_SIZE-1:0] lane_s,
  input  logic [BIT_SIZE-1:0] lane_s_bar
);

  localparam int unsigned CntW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PHASE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StPre, StStep0, StStep1, StStep2, StStep3, StStep4, StResp
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BIT_SIZE-1:0] x_q, x_d, k_q, k_d;
  logic [BIT_SIZE-1:0] out_s_q, out_s_d;
  logic                out_valid_q, out_valid_d;
  logic                sample;
  logic                last_cycle;

  logic [bits-1:0]     clk_d, dis_d;
  logic                dis_phase_d;

  assign last_cycle = (cnt_q == CntLast);
  assign in_ready   = (state_q == StIdle);
  assign out_valid  = out_valid_q;
  assign out_s      = out_s_q;

  // Sequencer next-state: step counter, operand capture, result sample, response handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    x_d         = x_q;
    k_d         = k_q;
    out_s_d     = out_s_q;
    out_valid_d = out_valid_q;
    sample      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = in_x;
          k_d     = in_k;
          state_d = StPre;
        end
      end
      StPre, StStep0, StStep1, StStep2, StStep3: begin
        if (last_cycle) state_d = state_e'(state_q + 3'd1);
        else            cnt_d   = cnt_q + 1'b1;
      end
      StStep4: begin
        if (last_cycle) begin
          sample  = 1'b1;
          out_s_d = lane_s;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        // out_valid comes up the cycle after entering RESP and stays until consumed.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Lane control decoded from the next state so the registered lane pins switch with the FSM.
  always_comb begin
    clk_d       = '0;
    dis_d       = '0;
    dis_phase_d = 1'b1;
    unique case (state_d)
      StPre:   dis_d = bits'(4'b0001);
      StStep0: begin clk_d = bits'(4'b0001); dis_d = bits'(4'b0010); end
      StStep1: begin clk_d = bits'(4'b0011); dis_d = bits'(4'b0100); end
      StStep2: begin clk_d = bits'(4'b0110); dis_d = bits'(4'b1000); end
      StStep3: clk_d = bits'(4'b1100);
      StStep4: clk_d = bits'(4'b1000);
      default: dis_phase_d = 1'b0;
    endcase
  end

  // Sequencer state, operands and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      x_q         <= '0;
      k_q         <= '0;
      out_s_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      k_q         <= k_d;
      out_s_q     <= out_s_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Registered lane pins; every rail is null (0) outside PRE..STEP4 so x and x_bar never meet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_clk       <= '0;
      lane_dis       <= '0;
      lane_dis_phase <= 1'b0;
      lane_x         <= '0;
      lane_x_bar     <= '0;
      lane_k         <= '0;
      lane_k_bar     <= '0;
    end else begin
      lane_clk       <= clk_d;
      lane_dis       <= dis_d;
      lane_dis_phase <= dis_phase_d;
      lane_x         <= dis_phase_d ? x_d  : '0;
      lane_x_bar     <= dis_phase_d ? ~x_d : '0;
      lane_k         <= dis_phase_d ? k_d  : '0;
      lane_k_bar     <= dis_phase_d ? ~k_d : '0;
    end
  end

`ifdef EESPFAL_RAIL_CHECK_EN
  logic err_q;

  // Any bit with equal rails at the sample point is a dual-rail violation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (sample) err_q <= |(~(lane_s ^ lane_s_bar));
  end

  assign out_err = err_q;
`else
  logic unused_rail;

  // The complement rail is only needed by the checker.
  assign unused_rail = sample ^ (^lane_s_bar);
  assign out_err     = 1'b0;
`endif

endmodule

// File: tb/tb_eespfal_lane_sequencer.sv
// Bench for eespfal_lane_sequencer: directed vectors, behavioural lane model, a per-cycle
// lane/handshake checker and a result scoreboard popped by a separate monitor.
module tb_eespfal_lane_sequencer;

  localparam int PC = 4;
`ifdef EESPFAL_RAIL_CHECK_EN
  localparam bit RailChk = 1'b1;
`else
  localparam bit RailChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_x = '0;
  logic [63:0] in_k = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_s;
  logic        out_err;
  logic [3:0]  lane_clk, lane_dis;
  logic        lane_dis_phase;
  logic [63:0] lane_x, lane_x_bar, lane_k, lane_k_bar;
  logic [63:0] lane_s, lane_s_bar;

  eespfal_lane_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_x           (in_x),
    .in_k           (in_k),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_s          (out_s),
    .out_err        (out_err),
    .lane_clk       (lane_clk),
    .lane_dis       (lane_dis),
    .lane_dis_phase (lane_dis_phase),
    .lane_x         (lane_x),
    .lane_x_bar     (lane_x_bar),
    .lane_k         (lane_k),
    .lane_k_bar     (lane_k_bar),
    .lane_s         (lane_s),
    .lane_s_bar     (lane_s_bar)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural lane: evaluates only while phase 3 clock is up, optional rail fault on bit 5.
  bit force_bad = 1'b0;
  always_comb begin
    lane_s     = '0;
    lane_s_bar = '0;
    if (lane_clk[3]) begin
      lane_s     = lane_x ^ lane_k;
      lane_s_bar = ~(lane_x ^ lane_k);
      if (force_bad) lane_s_bar[5] = lane_s[5];
    end
  end

  typedef struct {
    logic [63:0] x;
    logic [63:0] k;
    logic [63:0] s;
    bit          bad;
  } vec_t;
  vec_t tbl[8];

  typedef struct {
    logic [63:0] s;
    logic        err;
    int          acc;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [63:0] cur_s;
  logic        cur_err;

  task automatic set_inputs(input int i);
    in_x    = tbl[i].x;
    in_k    = tbl[i].k;
    cur_s   = tbl[i].s;
    cur_err = tbl[i].bad && RailChk;
  endtask

  // Per-cycle checker and accept tracker (pushes expected results).
  bit          busy = 1'b0;
  int          acc = 0;
  logic [63:0] ax, ak;
  always @(negedge clk) begin
    logic [3:0]   ec, ed;
    logic         edp, ev;
    logic [63:0]  ex, ek;
    int           r, p;
    if (!rst_n) begin
      busy = 1'b0;
      q.delete();
    end else begin
      ec = '0; ed = '0; edp = 1'b0; ev = 1'b0; ex = '0; ek = '0;
      if (busy) begin
        r = cyc - acc;
        if (r >= 1 && r <= 6 * PC) begin
          p   = (r - 1) / PC;
          edp = 1'b1;
          ex  = ax;
          ek  = ak;
          case (p)
            0: ed = 4'b0001;
            1: begin ec = 4'b0001; ed = 4'b0010; end
            2: begin ec = 4'b0011; ed = 4'b0100; end
            3: begin ec = 4'b0110; ed = 4'b1000; end
            4: ec = 4'b1100;
            default: ec = 4'b1000;
          endcase
        end
        ev = (r >= 6 * PC + 2);
      end
      check("lane_ctrl", {lane_clk, lane_dis, lane_dis_phase, out_valid, in_ready},
            {ec, ed, edp, ev, !busy});
      check("lane_ops", {lane_x, lane_x_bar, lane_k, lane_k_bar},
            {ex, edp ? ~ex : 64'h0, ek, edp ? ~ek : 64'h0});
      check("rail_clk_dis_overlap", {lane_x & lane_x_bar, lane_k & lane_k_bar,
            60'h0, lane_clk & lane_dis}, 256'h0);
      if (busy && out_valid && out_ready) begin
        busy = 1'b0;
      end else if (!busy && in_valid && in_ready) begin
        busy = 1'b1;
        acc  = cyc;
        ax   = in_x;
        ak   = in_k;
        q.push_back('{s: cur_s, err: cur_err, acc: cyc});
      end
    end
  end

  // Result monitor: latency on the rising out_valid, value compare on each handshake.
  bit ov_prev = 1'b0;
  bit b2b = 1'b0;
  int last_rise = -1;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (q.size() > 0) check("latency", 256'(cyc - q[0].acc), 256'(6 * PC + 2));
        if (b2b && last_rise >= 0) check("b2b_spacing", 256'(cyc - last_rise), 256'd27);
        last_rise = cyc;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got %0h expected none", out_s);
        end else begin
          e = q.pop_front();
          check("out_s", out_s, e.s);
          check("out_err", out_err, e.err);
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input int i, input bit hold);
    int n;
    @(posedge clk); #1;
    set_inputs(i);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) check("accept_timeout", 256'd0, 256'd1);
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || busy) check("drain_timeout", 256'(q.size()), 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, n;
    tbl[0] = '{64'hDEADBEEF_01234567, 64'hFFFF0000_FFFF0000, 64'h2152BEEF_FEDC4567, 1'b0};
    tbl[1] = '{64'h0, 64'h0, 64'h0, 1'b0};
    tbl[2] = '{64'hFFFFFFFF_FFFFFFFF, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
    tbl[3] = '{64'hAAAAAAAA_AAAAAAAA, 64'h55555555_55555555, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
    tbl[4] = '{64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 64'h0, 1'b0};
    tbl[5] = '{64'h0F0F0F0F_0F0F0F0F, 64'h00FF00FF_00FF00FF, 64'h0FF00FF0_0FF00FF0, 1'b0};
    tbl[6] = '{64'h00000000_00000001, 64'h00000000_00000020, 64'h00000000_00000021, 1'b1};
    tbl[7] = '{64'h80000000_00000000, 64'h00000000_00000001, 64'h80000000_00000001, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {lane_clk, lane_dis, lane_dis_phase, in_ready, out_valid, out_err},
          {4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    check("reset_ops", {lane_x, lane_x_bar, lane_k, lane_k_bar}, 256'h0);
    check("reset_out_s", out_s, 64'h0);
    rst_n = 1'b1;

    // Main vector.
    send(0, 1'b0);
    drain();

    // Asynchronous reset in the middle of STEP2.
    send(1, 1'b0);
    repeat (13) @(posedge clk);
    #1;
    check("pre_reset_step2", lane_clk, 4'b0110);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {lane_clk, lane_dis, lane_dis_phase, in_ready, out_valid},
          {4'h0, 4'h0, 1'b0, 1'b1, 1'b0});
    check("async_reset_ops", {lane_x, lane_x_bar, lane_k, lane_k_bar}, 256'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back with in_valid held.
    last_rise = -1;
    b2b = 1'b1;
    send(1, 1'b1);
    send(2, 1'b1);
    send(3, 1'b0);
    drain();
    b2b = 1'b0;

    send(4, 1'b0);
    drain();
    send(5, 1'b0);
    drain();

    // Backpressure with a second request presented while busy.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(2, 1'b0);
    @(posedge clk); #1;
    set_inputs(7);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    if (!out_valid) check("bp_valid_timeout", 256'd0, 256'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {out_valid, in_ready, out_s}, {1'b1, 1'b0, tbl[2].s});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    hs = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 5);
    check("bp_next_accept", 256'(cyc), 256'(hs + 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Dual-rail violation on bit 5.
    force_bad = 1'b1;
    send(6, 1'b0);
    drain();
    force_bad = 1'b0;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
